// File: rtl/axi_lite_addr_split.sv
// AXI4-lite 1-to-2 address splitter: routes each transaction to m0 when the
// masked address matches BASE, otherwise to the default slave on m1.
module axi_lite_addr_split #(
    parameter logic [31:0] BASE = 32'h4000_0000,
    parameter logic [31:0] MASK = 32'hFFFF_0000
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    // upstream slave port
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    // mapped register slave
    output logic [31:0] m0_axi_awaddr,
    output logic        m0_axi_awvalid,
    input  logic        m0_axi_awready,
    output logic [31:0] m0_axi_wdata,
    output logic [3:0]  m0_axi_wstrb,
    output logic        m0_axi_wvalid,
    input  logic        m0_axi_wready,
    input  logic [1:0]  m0_axi_bresp,
    input  logic        m0_axi_bvalid,
    output logic        m0_axi_bready,
    output logic [31:0] m0_axi_araddr,
    output logic        m0_axi_arvalid,
    input  logic        m0_axi_arready,
    input  logic [31:0] m0_axi_rdata,
    input  logic [1:0]  m0_axi_rresp,
    input  logic        m0_axi_rvalid,
    output logic        m0_axi_rready,
    // default (error) slave
    output logic [31:0] m1_axi_awaddr,
    output logic        m1_axi_awvalid,
    input  logic        m1_axi_awready,
    output logic [31:0] m1_axi_wdata,
    output logic [3:0]  m1_axi_wstrb,
    output logic        m1_axi_wvalid,
    input  logic        m1_axi_wready,
    input  logic [1:0]  m1_axi_bresp,
    input  logic        m1_axi_bvalid,
    output logic        m1_axi_bready,
    output logic [31:0] m1_axi_araddr,
    output logic        m1_axi_arvalid,
    input  logic        m1_axi_arready,
    input  logic [31:0] m1_axi_rdata,
    input  logic [1:0]  m1_axi_rresp,
    input  logic        m1_axi_rvalid,
    output logic        m1_axi_rready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    // Downstream handshake inputs of the selected port.
    logic sel_arready, sel_rvalid;
    logic sel_awready, sel_wready, sel_bvalid;

    assign sel_arready = sel_q ? m1_axi_arready : m0_axi_arready;
    assign sel_rvalid  = sel_q ? m1_axi_rvalid  : m0_axi_rvalid;
    assign sel_awready = sel_q ? m1_axi_awready : m0_axi_awready;
    assign sel_wready  = sel_q ? m1_axi_wready  : m0_axi_wready;
    assign sel_bvalid  = sel_q ? m1_axi_bvalid  : m0_axi_bvalid;

    // State and transaction context registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next state: accept one request in IDLE, then walk it through downstream.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (s_axi_arvalid) begin
                    addr_d  = s_axi_araddr;
                    sel_d   = ((s_axi_araddr & MASK) != BASE);
                    state_d = RD_A;
                end else if (s_axi_awvalid && s_axi_wvalid) begin
                    addr_d    = s_axi_awaddr;
                    wdata_d   = s_axi_wdata;
                    wstrb_d   = s_axi_wstrb;
                    sel_d     = ((s_axi_awaddr & MASK) != BASE);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_A;
                end
            end
            RD_A: begin
                if (sel_arready) state_d = RD_D;
            end
            RD_D: begin
                if (sel_rvalid && s_axi_rready) state_d = IDLE;
            end
            WR_A: begin
                aw_done_d = aw_done_q | sel_awready;
                w_done_d  = w_done_q | sel_wready;
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: begin
                if (sel_bvalid && s_axi_bready) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: readies/valids decoded from state, gated off while in reset.
    always_comb begin
        logic run, idle, rd_a, rd_d, wr_a, wr_b, wr_take;
        run     = s_axi_aresetn;
        idle    = run && (state_q == IDLE);
        rd_a    = run && (state_q == RD_A);
        rd_d    = run && (state_q == RD_D);
        wr_a    = run && (state_q == WR_A);
        wr_b    = run && (state_q == WR_B);
        wr_take = idle && !s_axi_arvalid && s_axi_awvalid && s_axi_wvalid;

        s_axi_arready = idle && s_axi_arvalid;
        s_axi_awready = wr_take;
        s_axi_wready  = wr_take;

        s_axi_rvalid = rd_d && sel_rvalid;
        s_axi_rdata  = sel_q ? m1_axi_rdata : m0_axi_rdata;
        s_axi_rresp  = sel_q ? m1_axi_rresp : m0_axi_rresp;
        s_axi_bvalid = wr_b && sel_bvalid;
        s_axi_bresp  = sel_q ? m1_axi_bresp : m0_axi_bresp;

        m0_axi_araddr  = addr_q;
        m0_axi_awaddr  = addr_q;
        m0_axi_wdata   = wdata_q;
        m0_axi_wstrb   = wstrb_q;
        m0_axi_arvalid = rd_a && !sel_q;
        m0_axi_rready  = rd_d && !sel_q && s_axi_rready;
        m0_axi_awvalid = wr_a && !sel_q && !aw_done_q;
        m0_axi_wvalid  = wr_a && !sel_q && !w_done_q;
        m0_axi_bready  = wr_b && !sel_q && s_axi_bready;

        m1_axi_araddr  = addr_q;
        m1_axi_awaddr  = addr_q;
        m1_axi_wdata   = wdata_q;
        m1_axi_wstrb   = wstrb_q;
        m1_axi_arvalid = rd_a && sel_q;
        m1_axi_rready  = rd_d && sel_q && s_axi_rready;
        m1_axi_awvalid = wr_a && sel_q && !aw_done_q;
        m1_axi_wvalid  = wr_a && sel_q && !w_done_q;
        m1_axi_bready  = wr_b && sel_q && s_axi_bready;
    end

endmodule
